// File: rtl/video_capture_data.sv
// video_capture_data: captures an external hs/vs/de video stream into the frame-buffer write FIFO,
// handshaking each frame with the writer and measuring the active frame size.
module video_capture_data #(
  parameter int DATA_WIDTH = 24,
  parameter bit VS_ACTIVE_HIGH = 1'b1
) (
  input  logic                  video_clk,
  input  logic                  rst,
  input  logic                  vin_hs,
  input  logic                  vin_vs,
  input  logic                  vin_de,
  input  logic [DATA_WIDTH-1:0] vin_data,
  output logic                  write_req,
  input  logic                  write_req_ack,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [11:0]           frame_width,
  output logic [11:0]           frame_height,
  output logic                  frame_done,
  output logic                  frame_drop
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, CAPTURE, SKIP} state_t;
  state_t state, state_n;
  logic vs_n, vs_d0, vs_d1, de_d0, de_d1, vs_start, de_fall, cap;
  logic [DATA_WIDTH-1:0] data_d0, data_n;
  logic req_n, en_n, done_n, drop_n;
  logic [11:0] h_cnt, v_cnt, line_width, h_n, v_n, lw_n, fw_n, fh_n;
  logic hs_unused;
  assign hs_unused = vin_hs;
  assign vs_n = VS_ACTIVE_HIGH ? vin_vs : ~vin_vs;
  assign vs_start = vs_d0 & ~vs_d1;
  assign de_fall = ~de_d0 & de_d1;
  always_ff @(posedge video_clk or posedge rst)
    if (rst) begin
      {vs_d1, vs_d0, de_d1, de_d0} <= '0;
      data_d0 <= '0;
    end else begin
      {vs_d1, vs_d0} <= {vs_d0, vs_n};
      {de_d1, de_d0} <= {de_d0, vin_de};
      data_d0 <= vin_data;
    end
  // an ack in WAIT_ACK already counts as capturing, so a pixel arriving with the ack is kept
  always_comb begin
    state_n = state;
    req_n = write_req & ~write_req_ack;
    done_n = 1'b0;
    drop_n = 1'b0;
    fw_n = frame_width;
    fh_n = frame_height;
    cap = 1'b0;
    case (state)
      IDLE: if (vs_start) begin
        req_n = 1'b1;
        state_n = WAIT_ACK;
      end
      WAIT_ACK: if (write_req_ack) begin
        cap = 1'b1;
        state_n = CAPTURE;
      end else if (vs_start | de_d0) begin
        drop_n = 1'b1;
        state_n = vs_start ? WAIT_ACK : SKIP;
      end
      CAPTURE: begin
        cap = 1'b1;
        if (vs_start) begin
          done_n = 1'b1;
          fw_n = line_width;
          fh_n = v_cnt;
          req_n = 1'b1;
          state_n = WAIT_ACK;
        end
      end
      SKIP: if (vs_start) begin
        req_n = 1'b1;
        state_n = WAIT_ACK;
      end
      default: state_n = IDLE;
    endcase
    en_n = cap & de_d0;
    data_n = cap ? data_d0 : write_data;
  end
  always_comb begin
    h_n = h_cnt;
    v_n = v_cnt;
    lw_n = line_width;
    if (vs_start) begin
      h_n = '0;
      v_n = '0;
    end else if (cap & de_fall) begin
      lw_n = h_cnt;
      h_n = '0;
      v_n = &v_cnt ? v_cnt : v_cnt + 12'd1;
    end else if (cap & de_d0) h_n = &h_cnt ? h_cnt : h_cnt + 12'd1;
  end
  always_ff @(posedge video_clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      write_req <= 1'b0;
      write_en <= 1'b0;
      write_data <= '0;
      frame_width <= '0;
      frame_height <= '0;
      frame_done <= 1'b0;
      frame_drop <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
      line_width <= '0;
    end else begin
      state <= state_n;
      write_req <= req_n;
      write_en <= en_n;
      write_data <= data_n;
      frame_width <= fw_n;
      frame_height <= fh_n;
      frame_done <= done_n;
      frame_drop <= drop_n;
      h_cnt <= h_n;
      v_cnt <= v_n;
      line_width <= lw_n;
    end
endmodule
